vram_write_scheduler: RTL and testbench
=======================================

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

Interface
REQ-001 SHALL have parameter AW, default 20, VRAM word-address width (matches address-FIFO data width).
REQ-002 SHALL have parameter DW, default 16, VRAM data width (matches data-FIFO data width).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive display grants while writes are pending.
REQ-004 SHALL have port clk  in  1  single clock for all logic; there is one clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports af_rempty in 1, af_rdata in AW, af_rinc out 1: address write-buffer FIFO read side.
REQ-007 SHALL have ports df_rempty in 1, df_rdata in DW, df_rinc out 1: data write-buffer FIFO read side.
REQ-008 SHALL have ports disp_req in 1, disp_addr in AW: display fetch request, held until granted.
REQ-009 SHALL have ports disp_grant out 1, disp_valid out 1, disp_rdata out DW: grant pulse, read-return pulse, returned word.
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW: VRAM port command.
REQ-011 SHALL have ports mem_ack in 1, mem_rdata in DW: VRAM completion strobe and read data, valid with mem_ack.
REQ-012 SHALL have port busy out 1: high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, POP, LOAD, WR, RD.
REQ-014 SHALL define wr_pending = !af_rempty && !df_rempty; one FIFO non-empty alone is not pending.
REQ-015 In IDLE: SHALL go to RD if disp_req && (!wr_pending || starve_cnt < STARVE_LIMIT); else to POP if wr_pending; else stay.
REQ-016 On IDLE->RD: SHALL latch disp_addr into mem_addr, pulse disp_grant for exactly one cycle, drive mem_we=0.
REQ-017 In POP (one cycle): SHALL assert af_rinc and df_rinc together, both high only in this cycle.
REQ-018 FIFO read model: popped word appears on af_rdata/df_rdata in the cycle after the rinc cycle; LOAD SHALL register both into mem_addr/mem_wdata, mem_we=1.
REQ-019 In WR and RD: mem_req SHALL be high (registered, first high the cycle after state entry) until the cycle mem_ack is sampled high, then deassert.
REQ-020 On mem_ack in WR: SHALL return to IDLE; one FIFO pop equals exactly one VRAM write.
REQ-021 On mem_ack in RD: SHALL register mem_rdata to disp_rdata and pulse disp_valid one cycle; return to IDLE.
REQ-022 mem_addr, mem_wdata, mem_we SHALL stay stable while mem_req is high.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each display grant with wr_pending high, clear on entry to POP, and clear in IDLE when !wr_pending.
REQ-024 Simultaneous disp_req and wr_pending with starve_cnt = STARVE_LIMIT: write SHALL win; display is granted next IDLE.
REQ-025 mem_ack outside WR/RD SHALL be ignored.
REQ-026 Minimum service time SHALL be 2 cycles idle->ack for reads and 4 cycles for writes (IDLE, POP, LOAD, WR).

Reset
REQ-027 While rst is high at a clk edge: state=IDLE, starve_cnt=0, all outputs 0 (mem_addr, mem_wdata, disp_rdata cleared).
REQ-028 Reset mid-transaction SHALL drop mem_req the next cycle; a word already popped is discarded, with no retry.

Structure
REQ-029 Package vram_sched_pkg SHALL hold the state enum and default AW/DW constants shared with the write-buffer FIFO wrappers.
REQ-030 No sub-module SHALL be required; arbitration and starvation counter are inline.

Verification
REQ-031 Single write: FIFOs hold addr 0x1A2B3/data 0xBEEF, ack 2 cycles after req -> one rinc pulse each, mem_we=1, mem_addr=0x1A2B3, mem_wdata=0xBEEF, busy low after ack.
REQ-032 Display read: disp_req addr 0x00010, ack with mem_rdata 0x1234 -> disp_grant 1 cycle, mem_we=0, disp_valid 1 cycle with 0x1234.
REQ-033 Starvation: disp_req held high, 3 writes queued, STARVE_LIMIT=4 -> 4 reads, 1 write, 4 reads, 1 write... until FIFOs empty.
REQ-034 Skew: af non-empty, df empty for 10 cycles -> no rinc, busy low; df fills -> write issued.
REQ-035 Reset during WR with mem_req high -> mem_req low next cycle, state IDLE, no further rinc until wr_pending re-evaluated.
REQ-036 Back-to-back: 8 queued writes, mem_ack immediate -> 8 writes in 8 x 4 cycles, addresses in FIFO order.

Source files
------------

// File: rtl/vram_write_scheduler_pkg.sv
// Types and default widths shared by the VRAM write scheduler, its port interface
// and the write-buffer FIFO wrappers.
package vram_sched_pkg;

   localparam int VRAM_AW = 20;
   localparam int VRAM_DW = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POP  = 3'd1,
      ST_LOAD = 3'd2,
      ST_WR   = 3'd3,
      ST_RD   = 3'd4
   } sched_state_e;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// Single-ported VRAM command/completion bus; the scheduler is the master side.
interface vram_if
   import vram_sched_pkg::*;
#(
   parameter int AW = VRAM_AW,
   parameter int DW = VRAM_DW
) ();

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/vram_write_scheduler.sv
// Shares one VRAM port between buffered CPU writes and display fetches; display wins
// until STARVE_LIMIT consecutive grants have passed over a pending write.
module vram_write_scheduler
   import vram_sched_pkg::*;
#(
   parameter int AW           = VRAM_AW,
   parameter int DW           = VRAM_DW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          af_rempty,
   input  logic [AW-1:0] af_rdata,
   output logic          af_rinc,
   input  logic          df_rempty,
   input  logic [DW-1:0] df_rdata,
   output logic          df_rinc,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_grant,
   output logic          disp_valid,
   output logic [DW-1:0] disp_rdata,
   vram_if.master        mem,
   output logic          busy
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   sched_state_e  state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          af_rinc_q, af_rinc_d;
   logic          df_rinc_q, df_rinc_d;
   logic          disp_grant_q, disp_grant_d;
   logic          disp_valid_q, disp_valid_d;
   logic [DW-1:0] disp_rdata_q, disp_rdata_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q;
   logic          wr_pending_s;

   // A write needs both halves buffered; one FIFO alone is not a pending write.
   assign wr_pending_s = !af_rempty && !df_rempty;

   // Next-state, arbitration and command-register update.
   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      af_rinc_d    = 1'b0;
      df_rinc_d    = 1'b0;
      disp_grant_d = 1'b0;
      disp_valid_d = 1'b0;
      disp_rdata_d = disp_rdata_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (!wr_pending_s) begin
               starve_d = {SW{1'b0}};
            end else begin
               starve_d = starve_q;
            end
            if (disp_req && (!wr_pending_s || (starve_q < STARVE_MAX))) begin
               state_d      = ST_RD;
               mem_addr_d   = disp_addr;
               mem_we_d     = 1'b0;
               mem_req_d    = 1'b1;
               disp_grant_d = 1'b1;
               // Only grants that pass over a waiting write count toward starvation.
               if (wr_pending_s) begin
                  starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
               end else begin
                  starve_d = {SW{1'b0}};
               end
            end else if (wr_pending_s) begin
               state_d   = ST_POP;
               af_rinc_d = 1'b1;
               df_rinc_d = 1'b1;
               starve_d  = {SW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_POP: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d     = ST_WR;
            mem_addr_d  = af_rdata;
            mem_wdata_d = df_rdata;
            mem_we_d    = 1'b1;
            mem_req_d   = 1'b1;
         end
         ST_WR: begin
            if (mem.mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end else begin
               state_d = ST_WR;
            end
         end
         ST_RD: begin
            if (mem.mem_ack) begin
               state_d      = ST_IDLE;
               mem_req_d    = 1'b0;
               disp_rdata_d = mem.mem_rdata;
               disp_valid_d = 1'b1;
            end else begin
               state_d = ST_RD;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; a reset abandons any popped word without retry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         starve_q     <= {SW{1'b0}};
         af_rinc_q    <= 1'b0;
         df_rinc_q    <= 1'b0;
         disp_grant_q <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_rdata_q <= {DW{1'b0}};
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {AW{1'b0}};
         mem_wdata_q  <= {DW{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         af_rinc_q    <= af_rinc_d;
         df_rinc_q    <= df_rinc_d;
         disp_grant_q <= disp_grant_d;
         disp_valid_q <= disp_valid_d;
         disp_rdata_q <= disp_rdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= (state_d != ST_IDLE);
      end
   end

   assign af_rinc       = af_rinc_q;
   assign df_rinc       = df_rinc_q;
   assign disp_grant    = disp_grant_q;
   assign disp_valid    = disp_valid_q;
   assign disp_rdata    = disp_rdata_q;
   assign busy          = busy_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Randomized self-checking bench: FIFO and VRAM models driven on the falling edge,
// scenario tasks compare the logged traffic against arbitration rules.
module tb_vram_write_scheduler;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int SL = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            cyc;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          af_rempty = 1'b1;
   logic [AW-1:0] af_rdata = '0;
   logic          af_rinc;
   logic          df_rempty = 1'b1;
   logic [DW-1:0] df_rdata = '0;
   logic          df_rinc;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic          disp_grant;
   logic          disp_valid;
   logic [DW-1:0] disp_rdata;
   logic          busy;

   vram_if #(.AW(AW), .DW(DW)) mem_bus ();

   vram_write_scheduler #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .af_rempty(af_rempty), .af_rdata(af_rdata), .af_rinc(af_rinc),
      .df_rempty(df_rempty), .df_rdata(df_rdata), .df_rinc(df_rinc),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_grant(disp_grant), .disp_valid(disp_valid), .disp_rdata(disp_rdata),
      .mem(mem_bus.master), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] afq[$];
   logic [DW-1:0] dfq[$];
   txn_t          txn_q[$];
   logic [DW-1:0] served_q[$];
   logic [DW-1:0] returned_q[$];
   int af_pops = 0, df_pops = 0, grant_cnt = 0, valid_cnt = 0;
   int grant_cyc = 0, valid_cyc = 0, proto_viol = 0;
   int req_age = 0, cur_lat = 0, lat_cfg = 0;
   logic stray_ack = 1'b0, force_rd_en = 1'b0;
   logic [DW-1:0] force_rd = '0;
   logic prev_grant = 1'b0, prev_valid = 1'b0;
   logic          snap_we;
   logic [AW-1:0] snap_addr;
   logic [DW-1:0] snap_wdata;
   logic [DW-1:0] rd_word;
   txn_t          t_new;
   int checks = 0, errors = 0;

   // FIFO read side, VRAM responder and traffic logger, all between clock edges.
   always @(negedge clk) begin
      if (af_rinc) begin
         af_pops++;
         if (afq.size() > 0) af_rdata = afq.pop_front();
      end
      if (df_rinc) begin
         df_pops++;
         if (dfq.size() > 0) df_rdata = dfq.pop_front();
      end
      if (af_rinc !== df_rinc) proto_viol++;
      if (disp_grant) begin
         grant_cnt++;
         grant_cyc = cyc;
         if (prev_grant) proto_viol++;
      end
      prev_grant = disp_grant;
      if (disp_valid) begin
         valid_cnt++;
         valid_cyc = cyc;
         returned_q.push_back(disp_rdata);
         if (prev_valid) proto_viol++;
      end
      prev_valid = disp_valid;
      if (mem_bus.mem_req) begin
         if (req_age == 0) begin
            cur_lat    = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
            snap_we    = mem_bus.mem_we;
            snap_addr  = mem_bus.mem_addr;
            snap_wdata = mem_bus.mem_wdata;
         end else if (mem_bus.mem_we !== snap_we || mem_bus.mem_addr !== snap_addr ||
                      mem_bus.mem_wdata !== snap_wdata) begin
            proto_viol++;
         end
         if (req_age == cur_lat) begin
            rd_word = force_rd_en ? force_rd : DW'($urandom);
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = rd_word;
            if (!mem_bus.mem_we) served_q.push_back(rd_word);
            t_new.we    = mem_bus.mem_we;
            t_new.addr  = mem_bus.mem_addr;
            t_new.wdata = mem_bus.mem_wdata;
            t_new.cyc   = cyc;
            txn_q.push_back(t_new);
         end else begin
            mem_bus.mem_ack = 1'b0;
         end
         req_age++;
      end else begin
         req_age           = 0;
         mem_bus.mem_ack   = stray_ack;
         mem_bus.mem_rdata = DW'($urandom);
      end
      af_rempty = (afq.size() == 0);
      df_rempty = (dfq.size() == 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_txns(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (txn_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++;
      if ({busy, disp_grant, disp_valid, af_rinc, df_rinc, mem_bus.mem_req, mem_bus.mem_we} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {busy, disp_grant, disp_valid, af_rinc, df_rinc, mem_bus.mem_req, mem_bus.mem_we});
      end
      checks++;
      if ({mem_bus.mem_addr, mem_bus.mem_wdata, disp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_bus: addr %h wdata %h rdata %h expected all 0",
                  mem_bus.mem_addr, mem_bus.mem_wdata, disp_rdata);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_single_write();
      int pc, p0;
      bit ok;
      txn_q.delete();
      lat_cfg = 2;
      p0 = af_pops;
      pc = cyc;
      afq.push_back(20'h1A2B3);
      dfq.push_back(16'hBEEF);
      wait_txns(1, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_write_timeout: got %0d txns expected 1", txn_q.size());
      end else begin
         checks++;
         if ({txn_q[0].we, txn_q[0].addr, txn_q[0].wdata} !== {1'b1, 20'h1A2B3, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_write_cmd: got we %b addr %h data %h expected 1 1a2b3 beef",
                     txn_q[0].we, txn_q[0].addr, txn_q[0].wdata);
         end
         checks++;
         if (txn_q[0].cyc - pc !== 5) begin
            errors++;
            $display("FAIL single_write_latency: got %0d expected 5", txn_q[0].cyc - pc);
         end
      end
      checks++;
      if ({busy, mem_bus.mem_req} !== 2'b00) begin
         errors++;
         $display("FAIL single_write_idle: got busy %b req %b expected 0 0", busy, mem_bus.mem_req);
      end
      checks++;
      if (af_pops - p0 !== 1 || df_pops - p0 !== 1) begin
         errors++;
         $display("FAIL single_write_pops: got af %0d df %0d expected 1 1", af_pops - p0, df_pops - p0);
      end
   endtask

   task automatic test_display_read();
      int rc, g0, v0;
      bit got, ok;
      txn_q.delete();
      lat_cfg     = 1;
      force_rd_en = 1'b1;
      force_rd    = 16'h1234;
      g0 = grant_cnt;
      v0 = valid_cnt;
      rc = cyc;
      disp_addr = 20'h00010;
      disp_req  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (disp_grant) begin
            got = 1'b1;
            break;
         end
      end
      disp_req = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL read_grant_timeout: got no grant expected grant");
      end
      wait_txns(1, 20, ok);
      tick(1);
      force_rd_en = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL read_timeout: got %0d txns expected 1", txn_q.size());
      end else if ({txn_q[0].we, txn_q[0].addr, txn_q[0].cyc - rc} !== {1'b0, 20'h00010, 32'sd2}) begin
         errors++;
         $display("FAIL read_cmd: got we %b addr %h lat %0d expected 0 00010 2",
                  txn_q[0].we, txn_q[0].addr, txn_q[0].cyc - rc);
      end
      checks++;
      if (grant_cyc - rc !== 1 || grant_cnt - g0 !== 1) begin
         errors++;
         $display("FAIL read_grant: got at +%0d count %0d expected +1 count 1", grant_cyc - rc, grant_cnt - g0);
      end
      checks++;
      if (valid_cyc - rc !== 3 || valid_cnt - v0 !== 1 || disp_rdata !== 16'h1234) begin
         errors++;
         $display("FAIL read_valid: got at +%0d count %0d data %h expected +3 count 1 data 1234",
                  valid_cyc - rc, valid_cnt - v0, disp_rdata);
      end
   endtask

   task automatic test_starvation();
      logic [AW-1:0] wa[3];
      logic [15:0] exp_we, got_we;
      int sc, pend, wi;
      bit ok, order_ok;
      txn_q.delete();
      lat_cfg = 0;
      for (int i = 0; i < 3; i++) begin
         wa[i] = AW'($urandom);
         afq.push_back(wa[i]);
         dfq.push_back(DW'($urandom));
      end
      disp_addr = 20'h00ABC;
      disp_req  = 1'b1;
      wait_txns(16, 200, ok);
      disp_req = 1'b0;
      tick(6);
      sc = 0;
      pend = 3;
      for (int i = 0; i < 16; i++) begin
         if (pend > 0 && sc >= SL) begin
            exp_we[i] = 1'b1;
            pend--;
            sc = 0;
         end else begin
            exp_we[i] = 1'b0;
            sc = (pend > 0) ? ((sc < SL) ? sc + 1 : sc) : 0;
         end
      end
      got_we = '0;
      wi = 0;
      order_ok = 1'b1;
      for (int i = 0; i < 16 && i < txn_q.size(); i++) begin
         got_we[i] = txn_q[i].we;
         if (txn_q[i].we) begin
            if (wi > 2 || txn_q[i].addr !== wa[wi]) order_ok = 1'b0;
            wi++;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL starve_timeout: got %0d txns expected 16", txn_q.size());
      end
      checks++;
      if (got_we !== exp_we) begin
         errors++;
         $display("FAIL starve_order: got we-pattern %b expected %b", got_we, exp_we);
      end
      checks++;
      if (!order_ok || wi !== 3) begin
         errors++;
         $display("FAIL starve_write_order: got %0d in-order writes expected 3", wi);
      end
   endtask

   task automatic test_skew();
      int p0, g0;
      bit busy_seen, ok;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      txn_q.delete();
      lat_cfg = 1;
      p0 = af_pops;
      g0 = grant_cnt + valid_cnt;
      a = AW'($urandom);
      d = DW'($urandom);
      afq.push_back(a);
      stray_ack = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (busy || af_rinc || df_rinc) busy_seen = 1'b1;
      end
      stray_ack = 1'b0;
      checks++;
      if (busy_seen || af_pops !== p0 || grant_cnt + valid_cnt !== g0) begin
         errors++;
         $display("FAIL skew_idle: got busy/rinc %b pops %0d expected 0 pops 0", busy_seen, af_pops - p0);
      end
      dfq.push_back(d);
      wait_txns(1, 30, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL skew_write_timeout: got %0d txns expected 1", txn_q.size());
      end else if ({txn_q[0].we, txn_q[0].addr, txn_q[0].wdata} !== {1'b1, a, d}) begin
         errors++;
         $display("FAIL skew_write: got %b %h %h expected 1 %h %h", txn_q[0].we, txn_q[0].addr, txn_q[0].wdata, a, d);
      end
   endtask

   task automatic test_reset_mid_write();
      int p0;
      bit got, ok;
      logic [AW-1:0] a2;
      txn_q.delete();
      lat_cfg = 50;
      p0 = af_pops;
      afq.push_back(AW'($urandom) | 20'h00001);
      dfq.push_back(DW'($urandom) | 16'h0001);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (mem_bus.mem_req) begin
            got = 1'b1;
            break;
         end
      end
      tick(2);
      rst = 1'b1;
      tick(1);
      checks++;
      if (!got || {mem_bus.mem_req, busy, mem_bus.mem_we} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_ctrl: got req-seen %b req %b busy %b we %b expected 1 0 0 0",
                  got, mem_bus.mem_req, busy, mem_bus.mem_we);
      end
      checks++;
      if ({mem_bus.mem_addr, mem_bus.mem_wdata, disp_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid_bus: addr %h wdata %h rdata %h expected all 0",
                  mem_bus.mem_addr, mem_bus.mem_wdata, disp_rdata);
      end
      rst = 1'b0;
      lat_cfg = 0;
      tick(5);
      checks++;
      if (af_pops - p0 !== 1 || txn_q.size() !== 0) begin
         errors++;
         $display("FAIL rst_mid_discard: got pops %0d txns %0d expected 1 0", af_pops - p0, txn_q.size());
      end
      a2 = AW'($urandom);
      afq.push_back(a2);
      dfq.push_back(DW'($urandom));
      wait_txns(1, 30, ok);
      checks++;
      if (!ok || txn_q[0].addr !== a2) begin
         errors++;
         $display("FAIL rst_mid_resume: got %0d txns expected write to %h", txn_q.size(), a2);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW+DW-1:0] exp_w[8];
      int pc;
      bit ok;
      txn_q.delete();
      lat_cfg = 0;
      pc = cyc;
      for (int i = 0; i < 8; i++) begin
         exp_w[i] = {AW'($urandom), DW'($urandom)};
         afq.push_back(exp_w[i][AW+DW-1:DW]);
         dfq.push_back(exp_w[i][DW-1:0]);
      end
      wait_txns(8, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d txns expected 8", txn_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if ({txn_q[i].we, txn_q[i].addr, txn_q[i].wdata} !== {1'b1, exp_w[i]}) begin
               errors++;
               $display("FAIL b2b_word%0d: got %b %h %h expected 1 %h", i,
                        txn_q[i].we, txn_q[i].addr, txn_q[i].wdata, exp_w[i]);
            end
         end
         checks++;
         if (txn_q[7].cyc - pc !== 31) begin
            errors++;
            $display("FAIL b2b_timing: got last ack at +%0d expected +31", txn_q[7].cyc - pc);
         end
      end
      tick(2);
   endtask

   task automatic test_random_mix();
      logic [AW+DW-1:0] exp_w[$];
      logic [AW+DW-1:0] w;
      int n, wi;
      bit got, idle_ok, wr_ok, rd_ok;
      txn_q.delete();
      served_q.delete();
      returned_q.delete();
      lat_cfg = -1;
      idle_ok = 1'b1;
      for (int it = 0; it < 12; it++) begin
         n = int'($urandom_range(2, 0));
         for (int k = 0; k < n; k++) begin
            w = {AW'($urandom), DW'($urandom)};
            exp_w.push_back(w);
            afq.push_back(w[AW+DW-1:DW]);
            dfq.push_back(w[DW-1:0]);
         end
         if ($urandom_range(1, 0) == 1) begin
            disp_addr = AW'($urandom);
            disp_req  = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
               tick(1);
               if (disp_grant) begin
                  got = 1'b1;
                  break;
               end
            end
            disp_req = 1'b0;
            if (!got) idle_ok = 1'b0;
         end
         got = 1'b0;
         for (int i = 0; i < 100; i++) begin
            tick(1);
            if (!busy && afq.size() == 0 && dfq.size() == 0) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) idle_ok = 1'b0;
      end
      tick(3);
      checks++;
      if (!idle_ok) begin
         errors++;
         $display("FAIL mix_timeout: got stalled scheduler expected progress");
      end
      wi = 0;
      wr_ok = 1'b1;
      foreach (txn_q[i]) begin
         if (txn_q[i].we) begin
            if (wi >= exp_w.size() || {txn_q[i].addr, txn_q[i].wdata} !== exp_w[wi]) wr_ok = 1'b0;
            wi++;
         end
      end
      checks++;
      if (!wr_ok || wi !== exp_w.size()) begin
         errors++;
         $display("FAIL mix_writes: got %0d writes (order ok %b) expected %0d in order", wi, wr_ok, exp_w.size());
      end
      rd_ok = (served_q.size() == returned_q.size());
      foreach (served_q[i]) if (i < returned_q.size() && served_q[i] !== returned_q[i]) rd_ok = 1'b0;
      checks++;
      if (!rd_ok) begin
         errors++;
         $display("FAIL mix_reads: got %0d returned expected %0d matching", returned_q.size(), served_q.size());
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (proto_viol !== 0) begin
         errors++;
         $display("FAIL protocol: got %0d violations expected 0", proto_viol);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_display_read();
      test_starvation();
      test_skew();
      test_reset_mid_write();
      test_back_to_back();
      test_random_mix();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
